// File: rtl/ptp_pkg.sv
// Shared types and default widths for the PTP timing-parameter update scheduler.
package ptp_pkg;

    localparam int unsigned TS_W_DEFAULT  = 27;
    localparam int unsigned CNT_W_DEFAULT = 27;

    typedef enum logic [1:0] {
        UPD_PERIOD = 2'd0,
        UPD_OFFSET = 2'd1,
        UPD_DRIFT  = 2'd2,
        UPD_RSVD   = 2'd3
    } upd_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        LOCKOUT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/ptp_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant is accepted.
module ptp_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // 1: requester 1 wins a tie; reset value favours requester 0.
    logic prio_q, prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (accept_i) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ptp_adj_scheduler.sv
// Arbitrates host and servo timing-parameter updates into the PTP clock core, holding
// off new updates while an offset adjustment counts down.
module ptp_adj_scheduler
    import ptp_pkg::*;
#(
    parameter int unsigned TS_W  = TS_W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_req_valid,
    output logic             host_req_ready,
    input  logic [1:0]       host_req_type,
    input  logic [TS_W-1:0]  host_req_value,
    input  logic [CNT_W-1:0] host_req_count,
    input  logic             servo_req_valid,
    output logic             servo_req_ready,
    input  logic [1:0]       servo_req_type,
    input  logic [TS_W-1:0]  servo_req_value,
    input  logic [CNT_W-1:0] servo_req_count,
    output logic [TS_W-1:0]  out_period_ns,
    output logic             out_period_valid,
    output logic [TS_W-1:0]  out_adj_ns,
    output logic [CNT_W-1:0] out_adj_count,
    output logic             out_adj_valid,
    output logic [TS_W-1:0]  out_drift_ns,
    output logic [CNT_W-1:0] out_drift_count,
    output logic             out_drift_valid,
    output logic             busy,
    output logic             err_bad_type
);

    sched_state_e     state_q, state_d;
    logic [TS_W-1:0]  period_q, period_d, adj_q, adj_d, drift_q, drift_d;
    logic [CNT_W-1:0] adj_cnt_q, adj_cnt_d, drift_cnt_q, drift_cnt_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_q, lock_d;
    logic [2:0]       strb_q, strb_d;  // {period, adj, drift}
    logic             err_q, err_d;

    logic [1:0]       gnt;
    logic             accept;
    upd_type_e        sel_type;
    logic [TS_W-1:0]  sel_value;
    logic [CNT_W-1:0] sel_count;

    // Readys are forced low while reset is asserted so nothing is accepted.
    ptp_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     ((state_q == IDLE) && rst_n),
        .req_i    ({servo_req_valid, host_req_valid}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign host_req_ready  = gnt[0];
    assign servo_req_ready = gnt[1];
    assign accept          = (host_req_valid && gnt[0]) || (servo_req_valid && gnt[1]);

    assign sel_type  = upd_type_e'(gnt[1] ? servo_req_type : host_req_type);
    assign sel_value = gnt[1] ? servo_req_value : host_req_value;
    assign sel_count = gnt[1] ? servo_req_count : host_req_count;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        adj_d       = adj_q;
        adj_cnt_d   = adj_cnt_q;
        drift_d     = drift_q;
        drift_cnt_d = drift_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        lock_d      = lock_q;
        strb_d      = 3'b000;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = APPLY;
                    lock_cnt_d = sel_count;
                    lock_d     = (sel_type == UPD_OFFSET) && (sel_count != '0);
                    unique case (sel_type)
                        UPD_PERIOD: begin
                            period_d  = sel_value;
                            strb_d[2] = 1'b1;
                        end
                        UPD_OFFSET: begin
                            adj_d     = sel_value;
                            adj_cnt_d = sel_count;
                            strb_d[1] = 1'b1;
                        end
                        UPD_DRIFT: begin
                            drift_d     = sel_value;
                            drift_cnt_d = sel_count;
                            strb_d[0]   = 1'b1;
                        end
                        UPD_RSVD: begin
                            err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            APPLY: begin
                state_d = lock_q ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                // Loaded with the offset count, so the lockout lasts exactly that many cycles.
                if (lock_cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            period_q    <= '0;
            adj_q       <= '0;
            adj_cnt_q   <= '0;
            drift_q     <= '0;
            drift_cnt_q <= '0;
            lock_cnt_q  <= '0;
            lock_q      <= 1'b0;
            strb_q      <= 3'b000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            adj_q       <= adj_d;
            adj_cnt_q   <= adj_cnt_d;
            drift_q     <= drift_d;
            drift_cnt_q <= drift_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_q      <= lock_d;
            strb_q      <= strb_d;
            err_q       <= err_d;
        end
    end

    assign out_period_ns    = period_q;
    assign out_period_valid = strb_q[2];
    assign out_adj_ns       = adj_q;
    assign out_adj_count    = adj_cnt_q;
    assign out_adj_valid    = strb_q[1];
    assign out_drift_ns     = drift_q;
    assign out_drift_count  = drift_cnt_q;
    assign out_drift_valid  = strb_q[0];
    assign busy             = (state_q != IDLE);
    assign err_bad_type     = err_q;

endmodule

// File: doc/ptp_adj_scheduler.md
Name: ptp_adj_scheduler

Overview:
- Sequences and arbitrates timing-parameter updates into the PTP clock core: period, offset and drift, each with a value and an applied-after cycle count.
- Two requesters, host config and servo loop, share one update path; round-robin grant.
- Emits single-cycle valid strobes plus held values on the core's period/adj/drift inputs.
- Locks out further updates while an offset adjustment is counting down, so offsets never overlap.

Parameters:
- TS_W, 27, width of ns values (period, offset, drift).
- CNT_W, 27, width of adjust/drift cycle counts.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- host_req_valid  in  1  host update request.
- host_req_ready  out  1  host request accepted this cycle when valid&&ready.
- host_req_type  in  2  0=period, 1=offset, 2=drift, 3=reserved.
- host_req_value  in  TS_W  ns value.
- host_req_count  in  CNT_W  cycle count (offset/drift only).
- servo_req_valid, servo_req_ready, servo_req_type, servo_req_value, servo_req_count: same as host, servo requester.
- out_period_ns  out  TS_W  period to core.
- out_period_valid  out  1  one-cycle strobe.
- out_adj_ns  out  TS_W  offset to core.
- out_adj_count  out  CNT_W  offset countdown to core.
- out_adj_valid  out  1  one-cycle strobe.
- out_drift_ns  out  TS_W  drift to core.
- out_drift_count  out  CNT_W  drift countdown to core.
- out_drift_valid  out  1  one-cycle strobe.
- busy  out  1  high in APPLY or LOCKOUT.
- err_bad_type  out  1  sticky; set on accepted type 3.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, all out_* values 0, all strobes 0, readys 0, busy 0, err_bad_type 0, RR pointer favours host. Any pending request is dropped; no strobe is emitted after reset.
- FSM states IDLE, APPLY, LOCKOUT.
- IDLE: ready is combinational and only in IDLE. If only one valid, that requester gets ready. If both are valid, the one not granted last gets ready. Accepting a request (valid&&ready) latches type, value and count and moves to APPLY. The RR pointer updates on accept only.
- APPLY (exactly 1 cycle): the strobe for the latched type is high for this one cycle. The matching out_* value and count registers update on the same edge and then hold until the next update of that type.
  - period: count ignored.
  - type 3: no strobe, no value change, err_bad_type set.
  - Next state: type offset with count>0 goes to LOCKOUT with lock_cnt=count; otherwise IDLE.
- LOCKOUT: both readys are 0 and lock_cnt decrements each cycle. Exit to IDLE on the cycle lock_cnt==1, so lockout is exactly count cycles after APPLY.
- Latency: accept at edge N, strobe visible in cycle N+1, ready earliest in cycle N+2. Maximum throughput is one update per 2 cycles.
- Valid without ready: the requester holds valid and payload stable until accepted; the block never drops a non-reset request.
- Offset count=0: applies immediately, no lockout.
- Widths: no arithmetic on values; lock_cnt is CNT_W bits and never wraps, because decrement happens only while it is >1.
- At most one strobe is high per cycle.

Decomposition:
- Package ptp_pkg: upd_type_e enum (UPD_PERIOD=0, UPD_OFFSET=1, UPD_DRIFT=2, UPD_RSVD=3), sched_state_e (IDLE, APPLY, LOCKOUT), TS_W/CNT_W defaults.
- One sub-module, ptp_rr_arb2: 2-way round-robin arbiter with valid inputs, grant outputs, accept-driven pointer update.

Test Plan:
- Host period: type=0, value=8, count=0 in IDLE. Required: host_req_ready=1; out_period_valid pulses 1 cycle later; out_period_ns=8; ready returns 2 cycles after accept.
- Both valid simultaneously from reset: host offset value=5 count=3, servo drift value=2 count=10.
  - Host is granted first.
  - out_adj_valid is strobed, then busy for 3 LOCKOUT cycles with both readys 0.
  - Servo is then granted and out_drift_ns=2, out_drift_count=10.
- Round-robin fairness: both requesters hold period requests continuously. Required: grants alternate host, servo, host, servo; strobes every 2 cycles.
- Reserved type from servo (type=3, value=7). Required: accepted, no strobe, out_* values unchanged, err_bad_type=1 and stays 1.
- Async reset during LOCKOUT: rst_n=0 in the 2nd of 5 lockout cycles. Required: immediately busy=0, all out_* = 0, no strobes. After release, a queued host request is accepted in the first IDLE cycle.
